// File: rtl/gamepad_evt_pkg.sv
// Shared constants, event payload layout and decode helpers for the gamepad event arbiter.
package gamepad_evt_pkg;

  localparam int unsigned NUM_PADS = 2;
  localparam int unsigned PAD_W    = 12;
  localparam int unsigned BTN_W    = 4;
  localparam int unsigned EVT_W    = 6;

  // Button indices within one pad slice
  localparam logic [BTN_W-1:0] BTN_R        = 4'd0;
  localparam logic [BTN_W-1:0] BTN_L        = 4'd1;
  localparam logic [BTN_W-1:0] BTN_X        = 4'd2;
  localparam logic [BTN_W-1:0] BTN_A        = 4'd3;
  localparam logic [BTN_W-1:0] BTN_RIGHT    = 4'd4;
  localparam logic [BTN_W-1:0] BTN_LEFT     = 4'd5;
  localparam logic [BTN_W-1:0] BTN_DOWN     = 4'd6;
  localparam logic [BTN_W-1:0] BTN_UP       = 4'd7;
  localparam logic [BTN_W-1:0] BTN_START    = 4'd8;
  localparam logic [BTN_W-1:0] BTN_SELECT   = 4'd9;
  localparam logic [BTN_W-1:0] BTN_Y        = 4'd10;
  localparam logic [BTN_W-1:0] BTN_B        = 4'd11;
  localparam logic [BTN_W-1:0] BTN_PRESENCE = 4'd15;

  // Event word bit positions
  localparam int unsigned EVT_PAD_BIT     = 5;
  localparam int unsigned EVT_PRESSED_BIT = 4;

  // Slice pattern the driver reports for a disconnected pad
  localparam logic [PAD_W-1:0] PAD_ABSENT = 12'hFFF;

  typedef struct packed {
    logic             pad;
    logic             pressed;
    logic [BTN_W-1:0] button;
  } evt_t;

  // Absent pad reads as all buttons released
  function automatic logic [PAD_W-1:0] decode_slice(input logic [PAD_W-1:0] slice);
    return (slice == PAD_ABSENT) ? '0 : slice;
  endfunction

  // Index of the lowest set bit (0 when the vector is empty)
  function automatic logic [BTN_W-1:0] lowest_set(input logic [PAD_W-1:0] vec);
    logic [BTN_W-1:0] idx;
    idx = BTN_W'(0);
    for (int i = PAD_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = BTN_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gamepad_evt_fifo.sv
// Synchronous event FIFO: push blocked while full, pop while non-empty, flush empties it.
module gamepad_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data_c,
  output logic                     full_c,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_d;
  logic             do_push;
  logic             do_pop;

  assign full_c      = (level == LW'(DEPTH));
  assign do_push     = push & ~full_c;
  assign do_pop      = pop & valid;
  assign head_data_c = mem_q[rd_ptr_q];

  // Next occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    level_d = level;
    case ({do_push, do_pop})
      2'b10:   level_d = level + LW'(1);
      2'b01:   level_d = level - LW'(1);
      default: level_d = level;
    endcase
  end

  // Pointers, occupancy and registered non-empty flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level    <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level    <= '0;
      valid    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level <= level_d;
      valid <= (level_d != '0);
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/gamepad_event_arbiter.sv
// Turns the two-pad button image into a serialized press/release event stream.
// Optional build macro GAMEPAD_EVT_PRESENCE_EN adds per-pad connect/disconnect
// events (button code 4'hF), served ahead of button 0 within a pad.
module gamepad_event_arbiter
  import gamepad_evt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          SINGLE_PAD = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [23:0]                   pad_data,
  input  logic                          flush,
  input  logic                          evt_ready,
  output logic                          evt_valid,
  output logic [5:0]                    evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          pending_any
);

  logic [NUM_PADS-1:0][PAD_W-1:0] cur_q;
  logic [NUM_PADS-1:0][PAD_W-1:0] cur_d;
  logic [NUM_PADS-1:0][PAD_W-1:0] rep_q;
  logic [NUM_PADS-1:0][PAD_W-1:0] rep_d;
  logic [NUM_PADS-1:0]            pad_pend;
  logic                           rr_q;
  logic                           rr_d;
  logic                           sel_pad;
  logic                           push_c;
  logic                           fifo_full_c;
  logic                           pending_any_d;
  evt_t                           push_evt;

`ifdef GAMEPAD_EVT_PRESENCE_EN
  logic [NUM_PADS-1:0] pres_cur_q;
  logic [NUM_PADS-1:0] pres_cur_d;
  logic [NUM_PADS-1:0] pres_rep_q;
  logic [NUM_PADS-1:0] pres_rep_d;
`endif

  // Decode the raw driver image; absent or disabled pads read as released
  always_comb begin
    cur_d[0] = decode_slice(pad_data[PAD_W-1:0]);
    cur_d[1] = SINGLE_PAD ? '0 : decode_slice(pad_data[2*PAD_W-1:PAD_W]);
`ifdef GAMEPAD_EVT_PRESENCE_EN
    pres_cur_d[0] = (pad_data[PAD_W-1:0] != PAD_ABSENT);
    pres_cur_d[1] = !SINGLE_PAD && (pad_data[2*PAD_W-1:PAD_W] != PAD_ABSENT);
`endif
  end

  // Round-robin pad choice, lowest pending index within the pad, reported-state update
  always_comb begin
    rep_d    = rep_q;
    rr_d     = rr_q;
    push_c   = 1'b0;
    sel_pad  = 1'b0;
    push_evt = '0;
`ifdef GAMEPAD_EVT_PRESENCE_EN
    pres_rep_d = pres_rep_q;
`endif
    for (int p = 0; p < NUM_PADS; p++) begin
      pad_pend[p] = |(cur_q[p] ^ rep_q[p]);
    end
`ifdef GAMEPAD_EVT_PRESENCE_EN
    pad_pend = pad_pend | (pres_cur_q ^ pres_rep_q);
`endif

    if (flush) begin
      rep_d = cur_q;
`ifdef GAMEPAD_EVT_PRESENCE_EN
      pres_rep_d = pres_cur_q;
`endif
    end else if (!fifo_full_c && (pad_pend != '0)) begin
      sel_pad      = (&pad_pend) ? rr_q : pad_pend[1];
      push_c       = 1'b1;
      rr_d         = ~sel_pad;
      push_evt.pad = sel_pad;
`ifdef GAMEPAD_EVT_PRESENCE_EN
      if (pres_cur_q[sel_pad] != pres_rep_q[sel_pad]) begin
        push_evt.button     = BTN_PRESENCE;
        push_evt.pressed    = pres_cur_q[sel_pad];
        pres_rep_d[sel_pad] = pres_cur_q[sel_pad];
      end else
`endif
      begin
        push_evt.button  = lowest_set(cur_q[sel_pad] ^ rep_q[sel_pad]);
        push_evt.pressed = cur_q[sel_pad][push_evt.button];
        rep_d[sel_pad][push_evt.button] = push_evt.pressed;
      end
    end

    pending_any_d = |(cur_d ^ rep_d);
`ifdef GAMEPAD_EVT_PRESENCE_EN
    pending_any_d = pending_any_d | (|(pres_cur_d ^ pres_rep_d));
`endif
  end

  // Sampled state, reported state, round-robin pointer and pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q       <= '0;
      rep_q       <= '0;
      rr_q        <= 1'b0;
      pending_any <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      rep_q       <= rep_d;
      rr_q        <= rr_d;
      pending_any <= pending_any_d;
    end
  end

`ifdef GAMEPAD_EVT_PRESENCE_EN
  // Sampled and reported presence per pad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_cur_q <= '0;
      pres_rep_q <= '0;
    end else begin
      pres_cur_q <= pres_cur_d;
      pres_rep_q <= pres_rep_d;
    end
  end
`endif

  gamepad_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .push        (push_c),
    .push_data   (push_evt),
    .pop         (evt_ready),
    .head_data_c (evt_data),
    .full_c      (fifo_full_c),
    .valid       (evt_valid),
    .level       (fifo_level)
  );

endmodule
